prog_sequencer: RTL and testbench

Run controller for the fetch stage. Sequences the processor through NPROG stored programs back-to-back by driving the program counter's Start input, choosing each program's entry point, and waiting for the core's Done for each program. It also reports per-program cycle counts and, as a build option, a watchdog timeout. Sits between the testbench/host handshake (Go/AllDone) and the core's Start/Done pins.

---
 rtl/prog_sequencer.sv | 167 ++++++++++++++++
 tb/tb_prog_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Run controller: launches NPROG programs back-to-back through the PC Start pin and reports per-program cycle counts.
// Optional watchdog built only when PROG_SEQ_WATCHDOG_EN is defined.
module prog_sequencer #(
   parameter int L         = 10,
   parameter int NPROG     = 3,
   parameter int STRIDE    = 256,
   parameter int START_LEN = 2,
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 50000
) (
   input  logic                                      i_clk,
   input  logic                                      i_reset_n,
   input  logic                                      i_go,
   input  logic                                      i_done,
   output logic                                      o_start,
   output logic [((NPROG > 1) ? $clog2(NPROG) : 1)-1:0] o_prog_sel,
   output logic [L-1:0]                              o_entry_addr,
   output logic                                      o_running,
   output logic                                      o_all_done,
   output logic                                      o_timeout,
   output logic [CNT_W-1:0]                          o_last_cycles
);

   localparam int PSW = (NPROG > 1) ? $clog2(NPROG) : 1;
   localparam int LW  = (START_LEN > 1) ? $clog2(START_LEN) : 1;
   localparam logic [PSW-1:0] LAST_SEL    = PSW'(NPROG - 1);
   localparam logic [LW-1:0]  LAST_LAUNCH = LW'(START_LEN - 1);
   localparam logic [L-1:0]   STRIDE_L    = L'(STRIDE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
      S_FINISH = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PSW-1:0]   r_prog_sel,   w_prog_sel_nxt;
   logic [L-1:0]     r_entry,      w_entry_nxt;
   logic [LW-1:0]    r_launch_cnt, w_launch_cnt_nxt;
   logic [CNT_W-1:0] r_run_cnt,    w_run_cnt_nxt;
   logic [CNT_W-1:0] r_last,       w_last_nxt;
   logic             r_start,      w_start_nxt;
   logic             r_running,    w_running_nxt;
   logic             r_all_done,   w_all_done_nxt;
   logic [CNT_W-1:0] w_run_inc;
   logic             w_wdog_hit;

   assign w_run_inc = (r_run_cnt == {CNT_W{1'b1}}) ? r_run_cnt : r_run_cnt + CNT_W'(1);

`ifdef PROG_SEQ_WATCHDOG_EN
   localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT);
   logic r_timeout;
   assign w_wdog_hit = (32'(w_run_inc) >= TIMEOUT_U);
   assign o_timeout  = r_timeout;

   // Timeout flag register: set on entry to ERROR, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= (w_state_nxt == S_ERROR);
      end
   end
`else
   assign w_wdog_hit = 1'b0;
   assign o_timeout  = 1'b0;
`endif

   // State and datapath registers; all outputs come straight from these.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state      <= S_IDLE;
         r_prog_sel   <= '0;
         r_entry      <= '0;
         r_launch_cnt <= '0;
         r_run_cnt    <= '0;
         r_last       <= '0;
         r_start      <= 1'b0;
         r_running    <= 1'b0;
         r_all_done   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_prog_sel   <= w_prog_sel_nxt;
         r_entry      <= w_entry_nxt;
         r_launch_cnt <= w_launch_cnt_nxt;
         r_run_cnt    <= w_run_cnt_nxt;
         r_last       <= w_last_nxt;
         r_start      <= w_start_nxt;
         r_running    <= w_running_nxt;
         r_all_done   <= w_all_done_nxt;
      end
   end

   // Next-state decode; Done takes priority over the watchdog in RUN.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_go) w_state_nxt = S_LAUNCH;
            else      w_state_nxt = S_IDLE;
         end
         S_LAUNCH: begin
            if (r_launch_cnt == LAST_LAUNCH) w_state_nxt = S_RUN;
            else                             w_state_nxt = S_LAUNCH;
         end
         S_RUN: begin
            if (i_done) begin
               if (r_prog_sel == LAST_SEL) w_state_nxt = S_FINISH;
               else                        w_state_nxt = S_LAUNCH;
            end else if (w_wdog_hit) begin
               w_state_nxt = S_ERROR;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_FINISH: begin
            if (!i_go) w_state_nxt = S_IDLE;
            else       w_state_nxt = S_FINISH;
         end
         S_ERROR: w_state_nxt = S_ERROR;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and counters, keyed on the transition being taken.
   always_comb begin
      w_start_nxt    = (w_state_nxt == S_LAUNCH);
      w_running_nxt  = (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_RUN);
      w_all_done_nxt = (w_state_nxt == S_FINISH);
      w_prog_sel_nxt = r_prog_sel;
      w_entry_nxt    = r_entry;
      w_last_nxt     = r_last;

      // Entry address accumulates STRIDE so it equals ProgSel*STRIDE modulo 2^L.
      if ((r_state == S_IDLE) && (w_state_nxt == S_LAUNCH)) begin
         w_prog_sel_nxt = '0;
         w_entry_nxt    = '0;
      end else if ((r_state == S_RUN) && (w_state_nxt == S_LAUNCH)) begin
         w_prog_sel_nxt = r_prog_sel + PSW'(1);
         w_entry_nxt    = r_entry + STRIDE_L;
      end else begin
         w_prog_sel_nxt = r_prog_sel;
         w_entry_nxt    = r_entry;
      end

      if ((r_state == S_LAUNCH) && (w_state_nxt == S_LAUNCH)) w_launch_cnt_nxt = r_launch_cnt + LW'(1);
      else                                                    w_launch_cnt_nxt = '0;

      if (w_state_nxt == S_LAUNCH)  w_run_cnt_nxt = '0;
      else if (r_state == S_RUN)    w_run_cnt_nxt = w_run_inc;
      else                          w_run_cnt_nxt = r_run_cnt;

      if ((r_state == S_RUN) && i_done) w_last_nxt = w_run_inc;
      else                              w_last_nxt = r_last;
   end

   assign o_start       = r_start;
   assign o_prog_sel    = r_prog_sel;
   assign o_entry_addr  = r_entry;
   assign o_running     = r_running;
   assign o_all_done    = r_all_done;
   assign o_last_cycles = r_last;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: program lengths are randomized and expected outputs
// are derived from the run-sequence rules (k*STRIDE entry, saturating RUN-cycle count).
module tb_prog_sequencer;

   localparam int L         = 10;
   localparam int NPROG     = 3;
   localparam int STRIDE    = 256;
   localparam int START_LEN = 2;
   localparam int CNT_W     = 5;
   localparam int TIMEOUT   = 20;
   localparam int PSW       = 2;
   localparam int VW        = 4 + PSW + L + CNT_W;

   logic              clk = 1'b0;
   logic              reset_n, go, done;
   logic              o_start, o_running, o_all_done, o_timeout;
   logic [PSW-1:0]    o_prog_sel;
   logic [L-1:0]      o_entry_addr;
   logic [CNT_W-1:0]  o_last_cycles;
   logic [VW-1:0]     obs_v;

   int checks   = 0;
   int errors   = 0;
   int exp_last = 0;
   int exp_sel  = 0;

   prog_sequencer #(
      .L(L), .NPROG(NPROG), .STRIDE(STRIDE), .START_LEN(START_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_go(go), .i_done(done),
      .o_start(o_start), .o_prog_sel(o_prog_sel), .o_entry_addr(o_entry_addr),
      .o_running(o_running), .o_all_done(o_all_done), .o_timeout(o_timeout),
      .o_last_cycles(o_last_cycles)
   );

   always #5 clk = ~clk;

   assign obs_v = {o_start, o_running, o_all_done, o_timeout, o_prog_sel, o_entry_addr, o_last_cycles};

   // Expected output vector: entry address is program index times STRIDE, modulo 2^L.
   function automatic logic [VW-1:0] exp_vec(bit s, bit r, bit a, bit t, int sel, int last);
      logic [L-1:0] e;
      e = L'((sel * STRIDE) % (1 << L));
      return {s, r, a, t, PSW'(sel), e, CNT_W'(last)};
   endfunction

   function automatic int sat(int n);
      return (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; go = 1'b0; done = 1'b0;
      repeat (3) step();
      if (obs_v !== exp_vec(0, 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL reset_state obs=%h exp=%h", obs_v, exp_vec(0, 0, 0, 0, 0, 0));
      end
      checks++;
      reset_n = 1'b1;
      step();
      if (obs_v !== exp_vec(0, 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL idle_after_reset obs=%h exp=%h", obs_v, exp_vec(0, 0, 0, 0, 0, 0));
      end
      checks++;
      exp_last = 0; exp_sel = 0;
   endtask

   // One complete Go..AllDone..IDLE sequence with the given RUN lengths per program.
   task automatic test_sequence(input string name, input int lens [NPROG], input int hold, input bit noise);
      go = 1'b1;
      step();
      for (int k = 0; k < NPROG; k++) begin
         for (int i = 0; i < START_LEN; i++) begin
            if (obs_v !== exp_vec(1, 1, 0, 0, k, exp_last)) begin
               errors++; $display("FAIL %s launch k=%0d i=%0d obs=%h exp=%h", name, k, i, obs_v, exp_vec(1, 1, 0, 0, k, exp_last));
            end
            checks++;
            if (noise) begin done = 1'($urandom_range(0, 1)); go = 1'($urandom_range(0, 1)); end
            step();
            done = 1'b0;
         end
         for (int r = 1; r <= lens[k]; r++) begin
            if (obs_v !== exp_vec(0, 1, 0, 0, k, exp_last)) begin
               errors++; $display("FAIL %s run k=%0d r=%0d obs=%h exp=%h", name, k, r, obs_v, exp_vec(0, 1, 0, 0, k, exp_last));
            end
            checks++;
            if (noise) go = 1'($urandom_range(0, 1));
            done = (r == lens[k]);
            step();
            done = 1'b0;
         end
         exp_last = sat(lens[k]);
      end
      exp_sel = NPROG - 1;
      for (int h = 0; h < hold; h++) begin
         go = 1'b1;
         if (obs_v !== exp_vec(0, 0, 1, 0, exp_sel, exp_last)) begin
            errors++; $display("FAIL %s finish h=%0d obs=%h exp=%h", name, h, obs_v, exp_vec(0, 0, 1, 0, exp_sel, exp_last));
         end
         checks++;
         step();
      end
      go = 1'b0;
      if (obs_v !== exp_vec(0, 0, 1, 0, exp_sel, exp_last)) begin
         errors++; $display("FAIL %s finish_last obs=%h exp=%h", name, obs_v, exp_vec(0, 0, 1, 0, exp_sel, exp_last));
      end
      checks++;
      step();
      if (obs_v !== exp_vec(0, 0, 0, 0, exp_sel, exp_last)) begin
         errors++; $display("FAIL %s back_to_idle obs=%h exp=%h", name, obs_v, exp_vec(0, 0, 0, 0, exp_sel, exp_last));
      end
      checks++;
   endtask

   task automatic test_spurious_done_idle;
      go = 1'b0;
      for (int i = 0; i < 4; i++) begin
         done = 1'($urandom_range(0, 1));
         step();
         if (obs_v !== exp_vec(0, 0, 0, 0, exp_sel, exp_last)) begin
            errors++; $display("FAIL spurious_idle i=%0d obs=%h exp=%h", i, obs_v, exp_vec(0, 0, 0, 0, exp_sel, exp_last));
         end
         checks++;
      end
      done = 1'b0;
   endtask

   task automatic test_reset_mid_run;
      go = 1'b1;
      step();
      repeat (START_LEN) step();
      repeat (2) step();
      done = 1'b1;
      step();
      done = 1'b0;
      repeat (START_LEN + 3) step();
      if (obs_v !== exp_vec(0, 1, 0, 0, 1, 3)) begin
         errors++; $display("FAIL mid_run_setup obs=%h exp=%h", obs_v, exp_vec(0, 1, 0, 0, 1, 3));
      end
      checks++;
      reset_n = 1'b0;
      step();
      if (obs_v !== exp_vec(0, 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL reset_mid_run obs=%h exp=%h", obs_v, exp_vec(0, 0, 0, 0, 0, 0));
      end
      checks++;
      reset_n = 1'b1; go = 1'b0;
      exp_last = 0; exp_sel = 0;
      step();
      if (obs_v !== exp_vec(0, 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL idle_after_mid_reset obs=%h exp=%h", obs_v, exp_vec(0, 0, 0, 0, 0, 0));
      end
      checks++;
   endtask

`ifdef PROG_SEQ_WATCHDOG_EN
   task automatic test_watchdog;
      go = 1'b1;
      step();
      repeat (START_LEN) step();
      for (int r = 1; r <= TIMEOUT; r++) begin
         if (obs_v !== exp_vec(0, 1, 0, 0, 0, exp_last)) begin
            errors++; $display("FAIL wdog_run r=%0d obs=%h exp=%h", r, obs_v, exp_vec(0, 1, 0, 0, 0, exp_last));
         end
         checks++;
         step();
      end
      for (int i = 0; i < 6; i++) begin
         if (obs_v !== exp_vec(0, 0, 0, 1, 0, exp_last)) begin
            errors++; $display("FAIL wdog_error i=%0d obs=%h exp=%h", i, obs_v, exp_vec(0, 0, 0, 1, 0, exp_last));
         end
         checks++;
         go = 1'($urandom_range(0, 1)); done = 1'($urandom_range(0, 1));
         step();
      end
      go = 1'b0; done = 1'b0; reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      exp_last = 0; exp_sel = 0;
      if (obs_v !== exp_vec(0, 0, 0, 0, 0, 0)) begin
         errors++; $display("FAIL wdog_reset obs=%h exp=%h", obs_v, exp_vec(0, 0, 0, 0, 0, 0));
      end
      checks++;
   endtask
`endif

   initial begin
      int lens [NPROG];
      test_reset();
      lens = '{10, 10, 10};
      test_sequence("full_sequence", lens, 5, 1'b0);
      test_spurious_done_idle();
      for (int n = 0; n < 4; n++) begin
         foreach (lens[j]) lens[j] = $urandom_range(1, 15);
         test_sequence("random_seq", lens, $urandom_range(0, 4), 1'b1);
      end
      lens = '{1, 1, 1};
      test_sequence("back_to_back", lens, 0, 1'b1);
      test_reset_mid_run();
`ifdef PROG_SEQ_WATCHDOG_EN
      test_watchdog();
      lens = '{TIMEOUT, 3, TIMEOUT};
      test_sequence("wdog_tie", lens, 1, 1'b0);
`else
      lens = '{25, 40, 1};
      test_sequence("long_saturate", lens, 1, 1'b1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
